// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/align block.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_e;

    localparam int unsigned WORD_BYTES      = 4;
    localparam int unsigned MAX_INSTR_BYTES = 8;

    function automatic int unsigned min_bytes(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/byte_queue.sv
// Circular byte buffer: word push starting at a byte offset, variable-length pop,
// and a zero-padded peek window taken from registered state only.
module byte_queue
    import fetch_pkg::*;
#(
    parameter int unsigned BUF_BYTES = 16,
    parameter int unsigned WIN_BYTES = 8,
    parameter int unsigned PTR_W     = $clog2(BUF_BYTES),
    parameter int unsigned CNT_W     = PTR_W + 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [8*WORD_BYTES-1:0] push_data_i,
    input  logic [1:0]              push_skip_i,
    input  logic                    pop_i,
    input  logic [3:0]              pop_len_i,
    output logic [CNT_W-1:0]        count_o,
    output logic [8*WIN_BYTES-1:0]  peek_o
);

    logic [7:0]       mem_q [BUF_BYTES];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       push_n;

    always_comb begin
        push_n   = push_i ? (3'(WORD_BYTES) - 3'(push_skip_i)) : 3'd0;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(pop_len_i);
            end
            count_d = count_q + CNT_W'(push_n) - (pop_i ? CNT_W'(pop_len_i) : CNT_W'(0));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Byte k of the word lands at wr_ptr + (k - skip); leading skipped bytes are dropped.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i && !reset_i) begin
            for (int k = 0; k < int'(WORD_BYTES); k++) begin
                if (k >= int'(push_skip_i)) begin
                    mem_q[wr_ptr_q + PTR_W'(k - int'(push_skip_i))] <= push_data_i[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        peek_o = '0;
        for (int k = 0; k < int'(WIN_BYTES); k++) begin
            if (CNT_W'(k) < count_q) begin
                peek_o[8*k +: 8] = mem_q[rd_ptr_q + PTR_W'(k)];
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_align_ctrl.sv
// Fetch sequencer feeding the decoder: issues word fetches, queues bytes, handles
// redirects (including stale in-flight responses) and checks consume legality.
module fetch_align_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned BUF_BYTES = 16,
    parameter int unsigned WIN_BYTES = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_1000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    output logic                   o_mem_req,
    output logic [31:0]            o_mem_addr,
    input  logic                   i_mem_gnt,
    input  logic                   i_mem_rvalid,
    input  logic [31:0]            i_mem_rdata,
    input  logic                   i_redirect,
    input  logic [31:0]            i_redirect_addr,
    output logic                   o_win_valid,
    output logic [8*WIN_BYTES-1:0] o_win_data,
    output logic [3:0]             o_win_bytes,
    output logic [31:0]            o_win_pc,
    input  logic                   i_consume,
    input  logic [3:0]             i_consume_len,
    output logic                   o_err
);

    localparam int unsigned PTR_W = $clog2(BUF_BYTES);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic [31:0]      win_pc_q, win_pc_d;
    logic [1:0]       skip_q, skip_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] count;
    logic             push, pop, consume_ok;

    assign o_win_bytes = 4'(min_bytes(32'(count), WIN_BYTES));
    assign o_win_valid = (count != '0);
    assign o_win_pc    = win_pc_q;
    assign o_err       = err_q;

    assign consume_ok = i_consume && !i_redirect && o_win_valid &&
                        (i_consume_len != 4'd0) && (i_consume_len <= o_win_bytes);

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        skip_d       = skip_q;
        win_pc_d     = win_pc_q;
        push         = 1'b0;
        pop          = consume_ok;
        err_d        = i_consume && !i_redirect && !consume_ok;
        o_mem_req    = 1'b0;
        o_mem_addr   = '0;

        if (consume_ok) begin
            win_pc_d = win_pc_q + 32'(i_consume_len);
        end

        unique case (state_q)
            S_IDLE: begin
                // Only request when a whole word is guaranteed to fit.
                if (count <= CNT_W'(BUF_BYTES - WORD_BYTES)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                o_mem_req  = 1'b1;
                o_mem_addr = {fetch_addr_q[31:2], 2'b00};
                if (i_mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_rvalid) begin
                    push         = 1'b1;
                    skip_d       = 2'd0;
                    fetch_addr_d = fetch_addr_q + 32'(WORD_BYTES);
                    state_d      = S_IDLE;
                end
            end
            S_DROP: begin
                if (i_mem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A granted-but-unanswered fetch must be absorbed in S_DROP before refetching.
        if (i_redirect) begin
            push         = 1'b0;
            pop          = 1'b0;
            fetch_addr_d = i_redirect_addr;
            skip_d       = i_redirect_addr[1:0];
            win_pc_d     = i_redirect_addr;
            unique case (state_q)
                S_IDLE:         state_d = S_REQ;
                S_REQ:          state_d = i_mem_gnt ? S_DROP : S_REQ;
                S_WAIT, S_DROP: state_d = i_mem_rvalid ? S_REQ : S_DROP;
                default:        state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            fetch_addr_q <= RESET_PC;
            skip_q       <= RESET_PC[1:0];
            win_pc_q     <= RESET_PC;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            skip_q       <= skip_d;
            win_pc_q     <= win_pc_d;
            err_q        <= err_d;
        end
    end

    byte_queue #(
        .BUF_BYTES (BUF_BYTES),
        .WIN_BYTES (WIN_BYTES)
    ) u_byte_queue (
        .clk_i       (i_clk),
        .reset_i     (i_reset),
        .flush_i     (i_redirect),
        .push_i      (push),
        .push_data_i (i_mem_rdata),
        .push_skip_i (skip_q),
        .pop_i       (pop),
        .pop_len_i   (i_consume_len),
        .count_o     (count),
        .peek_o      (o_win_data)
    );

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Directed bench for fetch_align_ctrl: fetch, consume, redirect, back-pressure,
// illegal consume and reset during an outstanding fetch.
module tb_fetch_align_ctrl;

    logic        i_clk;
    logic        i_reset;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_addr;
    logic        o_win_valid;
    logic [63:0] o_win_data;
    logic [3:0]  o_win_bytes;
    logic [31:0] o_win_pc;
    logic        i_consume;
    logic [3:0]  i_consume_len;
    logic        o_err;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_align_ctrl #(
        .BUF_BYTES (16),
        .WIN_BYTES (8),
        .RESET_PC  (32'h0000_1000)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .o_mem_req       (o_mem_req),
        .o_mem_addr      (o_mem_addr),
        .i_mem_gnt       (i_mem_gnt),
        .i_mem_rvalid    (i_mem_rvalid),
        .i_mem_rdata     (i_mem_rdata),
        .i_redirect      (i_redirect),
        .i_redirect_addr (i_redirect_addr),
        .o_win_valid     (o_win_valid),
        .o_win_data      (o_win_data),
        .o_win_bytes     (o_win_bytes),
        .o_win_pc        (o_win_pc),
        .i_consume       (i_consume),
        .i_consume_len   (i_consume_len),
        .o_err           (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_req(input int max_cyc);
        int n;
        n = 0;
        while (!o_mem_req && n < max_cyc) begin
            step();
            n++;
        end
        check("req_seen", 64'(o_mem_req), 64'd1);
    endtask

    // One granted fetch: check the address, grant, answer on the following cycle.
    task automatic fetch_word(input logic [31:0] exp_addr, input logic [31:0] data);
        wait_req(20);
        check("req_addr", 64'(o_mem_addr), 64'(exp_addr));
        i_mem_gnt = 1'b1;
        step();
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = data;
        step();
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
    endtask

    task automatic consume(input logic [3:0] len);
        i_consume     = 1'b1;
        i_consume_len = len;
        step();
        i_consume     = 1'b0;
        i_consume_len = '0;
    endtask

    task automatic redirect(input logic [31:0] addr);
        i_redirect      = 1'b1;
        i_redirect_addr = addr;
        step();
        i_redirect      = 1'b0;
        i_redirect_addr = '0;
    endtask

    initial begin
        logic seen_req;

        i_reset         = 1'b1;
        i_mem_gnt       = 1'b0;
        i_mem_rvalid    = 1'b0;
        i_mem_rdata     = '0;
        i_redirect      = 1'b0;
        i_redirect_addr = '0;
        i_consume       = 1'b0;
        i_consume_len   = '0;
        step();
        step();

        check("rst_req",   64'(o_mem_req),   64'd0);
        check("rst_valid", 64'(o_win_valid), 64'd0);
        check("rst_bytes", 64'(o_win_bytes), 64'd0);
        check("rst_data",  o_win_data,       64'd0);
        check("rst_pc",    64'(o_win_pc),    64'h1000);
        check("rst_err",   64'(o_err),       64'd0);
        i_reset = 1'b0;

        // Two aligned words build a full window.
        fetch_word(32'h1000, 32'h0403_0201);
        check("w1_bytes", 64'(o_win_bytes), 64'd4);
        check("w1_data",  o_win_data,       64'h0000_0000_0403_0201);
        fetch_word(32'h1004, 32'h0807_0605);
        check("w2_bytes", 64'(o_win_bytes), 64'd8);
        check("w2_data",  o_win_data,       64'h0807_0605_0403_0201);
        check("w2_pc",    64'(o_win_pc),    64'h1000);

        consume(4'd2);
        check("c2_pc",    64'(o_win_pc),    64'h1002);
        check("c2_byte0", 64'(o_win_data[7:0]), 64'h03);
        check("c2_bytes", 64'(o_win_bytes), 64'd6);
        check("c2_data",  o_win_data,       64'h0000_0807_0605_0403);
        check("c2_err",   64'(o_err),       64'd0);

        // Redirect while a fetch is outstanding; its response must be discarded.
        wait_req(20);
        check("pre_redir_addr", 64'(o_mem_addr), 64'h1008);
        i_mem_gnt = 1'b1;
        step();
        i_mem_gnt = 1'b0;
        redirect(32'h0000_2002);
        check("rd_valid", 64'(o_win_valid), 64'd0);
        check("rd_pc",    64'(o_win_pc),    64'h2002);
        check("rd_req",   64'(o_mem_req),   64'd0);
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hDEAD_BEEF;
        step();
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
        check("drop_valid", 64'(o_win_valid), 64'd0);
        check("drop_data",  o_win_data,       64'd0);
        fetch_word(32'h2000, 32'h4433_2211);
        check("ua_bytes", 64'(o_win_bytes), 64'd2);
        check("ua_data",  o_win_data,       64'h0000_0000_0000_4433);
        check("ua_pc",    64'(o_win_pc),    64'h2002);

        // Redirect from S_IDLE requests on the very next cycle.
        redirect(32'h0000_3001);
        check("r3_req",  64'(o_mem_req),  64'd1);
        check("r3_addr", 64'(o_mem_addr), 64'h3000);
        fetch_word(32'h3000, 32'hDDCC_BBAA);
        check("r3_bytes", 64'(o_win_bytes), 64'd3);
        check("r3_data",  o_win_data,       64'h0000_0000_00DD_CCBB);

        consume(4'd5);
        check("ill5_err",   64'(o_err),       64'd1);
        check("ill5_bytes", 64'(o_win_bytes), 64'd3);
        check("ill5_pc",    64'(o_win_pc),    64'h3001);
        check("ill5_data",  o_win_data,       64'h0000_0000_00DD_CCBB);
        step();
        check("err_pulse", 64'(o_err), 64'd0);
        consume(4'd0);
        check("ill0_err",   64'(o_err),       64'd1);
        check("ill0_bytes", 64'(o_win_bytes), 64'd3);
        check("ill0_pc",    64'(o_win_pc),    64'h3001);

        // Back-pressure: fill all 16 bytes, then fetching must stop.
        redirect(32'h0000_4000);
        fetch_word(32'h4000, 32'h0302_0100);
        fetch_word(32'h4004, 32'h0706_0504);
        fetch_word(32'h4008, 32'h0B0A_0908);
        fetch_word(32'h400C, 32'h0F0E_0D0C);
        check("bp_bytes", 64'(o_win_bytes), 64'd8);
        check("bp_data",  o_win_data,       64'h0706_0504_0302_0100);
        seen_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen_req = seen_req | o_mem_req;
            step();
        end
        check("bp_no_req", 64'(seen_req), 64'd0);
        consume(4'd4);
        check("bp_c_pc",   64'(o_win_pc),  64'h4004);
        check("bp_c_data", o_win_data,     64'h0B0A_0908_0706_0504);
        step();
        check("bp_req_back", 64'(o_mem_req),  64'd1);
        check("bp_req_addr", 64'(o_mem_addr), 64'h4010);

        // Reset with a response arriving in the same cycle.
        i_mem_gnt = 1'b1;
        step();
        i_mem_gnt    = 1'b0;
        i_reset      = 1'b1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h5555_AAAA;
        step();
        i_reset      = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
        check("mr_req",   64'(o_mem_req),   64'd0);
        check("mr_valid", 64'(o_win_valid), 64'd0);
        check("mr_bytes", 64'(o_win_bytes), 64'd0);
        check("mr_data",  o_win_data,       64'd0);
        check("mr_pc",    64'(o_win_pc),    64'h1000);
        check("mr_err",   64'(o_err),       64'd0);
        wait_req(20);
        check("mr_addr", 64'(o_mem_addr), 64'h1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
